inst_fetch_unit: RTL and testbench

- Initiator side of the instruction-fetch interface served by the cache controller.
- Holds the fetch PC and drives start_fetch/pc; captures inst/inst_addr when fetch_ready is asserted.
- Statically predicts JAL targets (all other instructions predicted PC+4) and buffers fetched instructions in a FIFO that the decoder drains through a valid/ready handshake.
- Flushes and redirects on rob_clear_up.

---
 rtl/inst_fetch_unit_if.sv | 38 +++
 rtl/inst_fetch_unit.sv | 117 +++++++++++
 tb/tb_inst_fetch_unit.sv | 252 +++++++++++++++++++++++++
 3 files changed

// File: rtl/inst_fetch_unit_if.sv
`timescale 1ns / 1ps
// inst_fetch_unit_if
// Groups the two handshakes of the instruction fetch unit:
//   - fetch side : start_fetch/pc out to the cache controller,
//                  fetch_ready/inst/inst_addr back from it.
//   - queue side : iq_valid/iq_inst/iq_pc/iq_pred_pc out to the decoder,
//                  iq_ready back from it.
// Modports:
//   master - the fetch unit (drives requests and the queue head)
//   slave  - the controller/decoder side (drives responses and iq_ready)
//
// Handshake semantics: a queue entry transfers on a cycle where
// iq_valid && iq_ready (and the global rdy_in is high). iq_valid never
// depends on iq_ready. start_fetch is a level request; the controller
// answers with a one-cycle fetch_ready strobe, and the answer only counts
// when inst_addr matches the pc currently requested.
interface inst_fetch_unit_if;
  logic        start_fetch;
  logic [31:0] pc;
  logic        fetch_ready;
  logic [31:0] inst;
  logic [31:0] inst_addr;
  logic        iq_valid;
  logic [31:0] iq_inst;
  logic [31:0] iq_pc;
  logic [31:0] iq_pred_pc;
  logic        iq_ready;

  modport master (
    output start_fetch, pc, iq_valid, iq_inst, iq_pc, iq_pred_pc,
    input  fetch_ready, inst, inst_addr, iq_ready
  );

  modport slave (
    input  start_fetch, pc, iq_valid, iq_inst, iq_pc, iq_pred_pc,
    output fetch_ready, inst, inst_addr, iq_ready
  );
endinterface

// File: rtl/inst_fetch_unit.sv
`timescale 1ns / 1ps
// inst_fetch_unit
// Holds the fetch PC, requests instructions from the cache controller,
// statically predicts JAL targets (everything else falls through to pc+4)
// and buffers fetched instructions in a DEPTH-entry FIFO for the decoder.
// A ROB flush empties the queue and redirects the PC.
// Ports:
//   clk_in          - clock, all state on posedge
//   rst_in          - asynchronous active-high reset
//   rdy_in          - global ready; when low every register holds
//   rob_clear_up    - pipeline flush request
//   rob_redirect_pc - PC to resume from on flush
//   bus             - fetch + queue handshakes (master modport)
//   o_dbg_state     - fetch FSM state (0 = REQ, 1 = FLUSH)
module inst_fetch_unit #(
  parameter int          DEPTH    = 8,
  parameter logic [31:0] RESET_PC = 32'h0
) (
  input  logic                clk_in,
  input  logic                rst_in,
  input  logic                rdy_in,
  input  logic                rob_clear_up,
  input  logic [31:0]         rob_redirect_pc,
  inst_fetch_unit_if.master   bus,
  output logic                o_dbg_state
);

  localparam int            AW       = $clog2(DEPTH);
  localparam logic [AW:0]   FULL_CNT = (AW + 1)'(DEPTH);
  localparam logic [6:0]    OP_JAL   = 7'b1101111;

  typedef enum logic {
    S_REQ   = 1'b0,
    S_FLUSH = 1'b1
  } state_t;

  state_t        r_state;
  logic [31:0]   r_pc;
  logic [AW-1:0] r_head;
  logic [AW-1:0] r_tail;
  logic [AW:0]   r_count;
  logic [31:0]   r_mem_inst [DEPTH];
  logic [31:0]   r_mem_pc   [DEPTH];
  logic [31:0]   r_mem_pred [DEPTH];

  logic          w_accept;
  logic          w_pop;
  logic          w_is_jal;
  logic [31:0]   w_jal_imm;
  logic [31:0]   w_npc;

  // The request drops during a flush so no response can be taken in the
  // same cycle the queue is emptied.
  assign bus.start_fetch = !rst_in && (r_count < FULL_CNT) && !rob_clear_up;
  assign bus.pc          = r_pc;

  // A response for any address other than the pending pc is stale (e.g.
  // issued before a flush) and is simply ignored.
  assign w_accept = bus.start_fetch && bus.fetch_ready &&
                    (bus.inst_addr == r_pc) && rdy_in;
  assign w_pop    = (r_count != '0) && bus.iq_ready && rdy_in;

  assign w_is_jal  = (bus.inst[6:0] == OP_JAL);
  assign w_jal_imm = {{11{bus.inst[31]}}, bus.inst[31], bus.inst[19:12],
                      bus.inst[20], bus.inst[30:21], 1'b0};
  assign w_npc     = w_is_jal ? (r_pc + w_jal_imm) : (r_pc + 32'd4);

  assign bus.iq_valid   = (r_count != '0);
  assign bus.iq_inst    = r_mem_inst[r_head];
  assign bus.iq_pc      = r_mem_pc[r_head];
  assign bus.iq_pred_pc = r_mem_pred[r_head];

  assign o_dbg_state = r_state;

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      r_state <= S_REQ;
      r_pc    <= RESET_PC;
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        r_mem_inst[i] <= '0;
        r_mem_pc[i]   <= '0;
        r_mem_pred[i] <= '0;
      end
    end else if (rdy_in) begin
      if (rob_clear_up) begin
        // Flush wins over any push or pop in the same cycle.
        r_state <= S_FLUSH;
        r_pc    <= rob_redirect_pc;
        r_head  <= '0;
        r_tail  <= '0;
        r_count <= '0;
      end else begin
        // FLUSH lasts exactly one cycle; fetching is already allowed there.
        r_state <= S_REQ;
        if (w_accept) begin
          r_mem_inst[r_tail] <= bus.inst;
          r_mem_pc[r_tail]   <= r_pc;
          r_mem_pred[r_tail] <= w_npc;
          r_tail             <= r_tail + 1'b1;
          r_pc               <= w_npc;
        end
        if (w_pop) begin
          r_head <= r_head + 1'b1;
        end
        case ({w_accept, w_pop})
          2'b10:   r_count <= r_count + 1'b1;
          2'b01:   r_count <= r_count - 1'b1;
          default: r_count <= r_count;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_inst_fetch_unit.sv
`timescale 1ns / 1ps
module tb_inst_fetch_unit;

  // ---------------- clock / reset ----------------
  logic        clk_in = 1'b0;
  logic        rst_in;
  logic        rdy_in;
  logic        rob_clear_up;
  logic [31:0] rob_redirect_pc;
  logic        o_dbg_state;

  int n_asserts = 0;
  int n_fail    = 0;

  always #5 clk_in = ~clk_in;

  inst_fetch_unit_if bus ();

  inst_fetch_unit #(
    .DEPTH    (8),
    .RESET_PC (32'h0)
  ) dut (
    .clk_in          (clk_in),
    .rst_in          (rst_in),
    .rdy_in          (rdy_in),
    .rob_clear_up    (rob_clear_up),
    .rob_redirect_pc (rob_redirect_pc),
    .bus             (bus),
    .o_dbg_state     (o_dbg_state)
  );

  // ---------------- checker ----------------
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_asserts++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  // Inputs change 1ns after the rising edge; outputs are checked there too.
  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  task automatic resp(input logic [31:0] addr, input logic [31:0] word);
    bus.fetch_ready = 1'b1;
    bus.inst_addr   = addr;
    bus.inst        = word;
  endtask

  task automatic idle();
    bus.fetch_ready = 1'b0;
    bus.inst_addr   = 32'h0;
    bus.inst        = 32'h0;
  endtask

  task automatic flush(input logic [31:0] target);
    idle();
    rob_clear_up    = 1'b1;
    rob_redirect_pc = target;
    tick();
    rob_clear_up    = 1'b0;
  endtask

  localparam logic [31:0] NOP = 32'h00000013;

  initial begin
    rst_in          = 1'b1;
    rdy_in          = 1'b1;
    rob_clear_up    = 1'b0;
    rob_redirect_pc = 32'h0;
    bus.iq_ready    = 1'b0;
    idle();

    // ---- reset state ----
    repeat (2) @(posedge clk_in);
    #1;
    chk("rst_pc", bus.pc, 32'h0);
    chk("rst_start", 32'(bus.start_fetch), 32'h0);
    chk("rst_valid", 32'(bus.iq_valid), 32'h0);
    chk("rst_inst", bus.iq_inst, 32'h0);
    chk("rst_iqpc", bus.iq_pc, 32'h0);
    chk("rst_pred", bus.iq_pred_pc, 32'h0);
    chk("rst_state", 32'(o_dbg_state), 32'h0);
    rst_in = 1'b0;
    #1;
    chk("first_req", 32'(bus.start_fetch), 32'h1);

    // ---- sequential fetch 0,4,8 ----
    resp(32'h0, NOP);
    tick();
    chk("seq_pc4", bus.pc, 32'h4);
    chk("seq_valid", 32'(bus.iq_valid), 32'h1);
    chk("seq_h0_pc", bus.iq_pc, 32'h0);
    chk("seq_h0_pred", bus.iq_pred_pc, 32'h4);
    chk("seq_h0_inst", bus.iq_inst, NOP);
    resp(32'h4, NOP);
    tick();
    chk("seq_pc8", bus.pc, 32'h8);
    resp(32'h8, NOP);
    tick();
    chk("seq_pcC", bus.pc, 32'hC);
    idle();
    bus.iq_ready = 1'b1;
    tick();
    chk("seq_h1_pc", bus.iq_pc, 32'h4);
    chk("seq_h1_pred", bus.iq_pred_pc, 32'h8);
    tick();
    chk("seq_h2_pc", bus.iq_pc, 32'h8);
    chk("seq_h2_pred", bus.iq_pred_pc, 32'hC);
    tick();
    chk("seq_empty", 32'(bus.iq_valid), 32'h0);
    bus.iq_ready = 1'b0;

    // ---- JAL forward ----
    rob_clear_up    = 1'b1;
    rob_redirect_pc = 32'h20;
    #1;
    chk("flush_start_low", 32'(bus.start_fetch), 32'h0);
    tick();
    rob_clear_up = 1'b0;
    chk("redir_pc20", bus.pc, 32'h20);
    chk("flush_state", 32'(o_dbg_state), 32'h1);
    chk("flush_empty", 32'(bus.iq_valid), 32'h0);
    resp(32'h20, 32'h0100006F);
    tick();
    chk("jal_fwd_pc", bus.pc, 32'h30);
    chk("jal_fwd_iqpc", bus.iq_pc, 32'h20);
    chk("jal_fwd_pred", bus.iq_pred_pc, 32'h30);
    chk("req_state", 32'(o_dbg_state), 32'h0);

    // ---- JAL backward ----
    flush(32'h10);
    resp(32'h10, 32'hFF9FF06F);
    tick();
    chk("jal_bwd_pc", bus.pc, 32'h8);
    chk("jal_bwd_iqpc", bus.iq_pc, 32'h10);
    chk("jal_bwd_pred", bus.iq_pred_pc, 32'h8);

    // ---- mismatched response address ----
    flush(32'h44);
    resp(32'h40, NOP);
    tick();
    chk("mis_pc", bus.pc, 32'h44);
    chk("mis_empty", 32'(bus.iq_valid), 32'h0);
    chk("mis_pending", 32'(bus.start_fetch), 32'h1);

    // ---- pc wraparound ----
    flush(32'hFFFFFFFC);
    resp(32'hFFFFFFFC, NOP);
    tick();
    chk("wrap_pc", bus.pc, 32'h0);
    chk("wrap_pred", bus.iq_pred_pc, 32'h0);

    // ---- fill queue to DEPTH ----
    flush(32'h200);
    for (int k = 0; k < 8; k++) begin
      resp(32'h200 + 32'(4 * k), NOP);
      tick();
    end
    chk("full_start", 32'(bus.start_fetch), 32'h0);
    chk("full_pc", bus.pc, 32'h220);
    chk("full_head", bus.iq_pc, 32'h200);
    resp(32'h220, NOP);
    tick();
    chk("full_nopush_pc", bus.pc, 32'h220);
    idle();
    bus.iq_ready = 1'b1;
    tick();
    bus.iq_ready = 1'b0;
    chk("pop_start", 32'(bus.start_fetch), 32'h1);
    chk("pop_head", bus.iq_pc, 32'h204);
    resp(32'h220, NOP);
    bus.iq_ready = 1'b1;
    tick();
    chk("pushpop_start", 32'(bus.start_fetch), 32'h1);
    chk("pushpop_pc", bus.pc, 32'h224);
    chk("pushpop_head", bus.iq_pc, 32'h208);
    bus.iq_ready = 1'b0;
    resp(32'h224, NOP);
    tick();
    chk("refull_start", 32'(bus.start_fetch), 32'h0);
    chk("refull_pc", bus.pc, 32'h228);
    idle();
    bus.iq_ready = 1'b1;
    for (int k = 0; k < 8; k++) begin
      chk("drain_valid", 32'(bus.iq_valid), 32'h1);
      chk("drain_pc", bus.iq_pc, 32'h208 + 32'(4 * k));
      tick();
    end
    chk("drain_empty", 32'(bus.iq_valid), 32'h0);
    bus.iq_ready = 1'b0;

    // ---- rdy_in low freezes everything ----
    resp(32'h228, NOP);
    tick();
    resp(32'h22C, NOP);
    tick();
    rdy_in = 1'b0;
    resp(32'h230, NOP);
    bus.iq_ready = 1'b1;
    repeat (3) begin
      tick();
      chk("frz_pc", bus.pc, 32'h230);
      chk("frz_head", bus.iq_pc, 32'h228);
      chk("frz_valid", 32'(bus.iq_valid), 32'h1);
    end
    rdy_in = 1'b1;
    bus.iq_ready = 1'b0;
    tick();
    chk("thaw_pc", bus.pc, 32'h234);

    // ---- flush with 3 entries and a same-cycle response ----
    rob_clear_up    = 1'b1;
    rob_redirect_pc = 32'h100;
    resp(32'h234, NOP);
    #1;
    chk("fl3_start_low", 32'(bus.start_fetch), 32'h0);
    tick();
    rob_clear_up = 1'b0;
    idle();
    chk("fl3_empty", 32'(bus.iq_valid), 32'h0);
    chk("fl3_pc", bus.pc, 32'h100);
    tick();
    chk("fl3_dropped", 32'(bus.iq_valid), 32'h0);
    chk("fl3_state", 32'(o_dbg_state), 32'h0);
    chk("fl3_resume", 32'(bus.start_fetch), 32'h1);

    // ---- reset mid-fetch ----
    resp(32'h100, NOP);
    #1;
    rst_in = 1'b1;
    #1;
    chk("arst_pc", bus.pc, 32'h0);
    chk("arst_start", 32'(bus.start_fetch), 32'h0);
    tick();
    chk("arst_hold_pc", bus.pc, 32'h0);
    chk("arst_valid", 32'(bus.iq_valid), 32'h0);
    idle();
    rst_in = 1'b0;
    tick();
    chk("arst_rel_pc", bus.pc, 32'h0);
    chk("arst_rel_start", 32'(bus.start_fetch), 32'h1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end

endmodule
